// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state encoding and index-width helper for mux_rr_arbiter
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width for an N-way select; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first asserted request at or after ptr
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int SW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic [SW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int k;
        k      = 0;
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[k]) begin
                o_any     = 1'b1;
                o_pick[k] = 1'b1;
                o_idx     = SW'(k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - packet-granular round-robin N:1 stream arbiter and mux
// Optional stall watchdog: MUX_RR_ARBITER_WATCHDOG_EN
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int W       = 8,
    parameter int TIMEOUT = 16,
    localparam int SW     = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*W-1:0]  req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic [N-1:0]    grant,
    output logic [SW-1:0]   sel,
    output logic            err
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_ptr_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_grant_nxt;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] w_sel_nxt;

    logic [N-1:0]  w_pick;
    logic [SW-1:0] w_pick_idx;
    logic          w_any;
    logic          w_active;
    logic          w_xfer;
    logic          w_wd_hit;
    logic [SW-1:0] w_ptr_after;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Datapath is gated by rst so nothing handshakes during the reset edge.
    always_comb begin
        w_active    = (r_state == BUSY) && !rst;
        out_valid   = w_active && req_valid[r_sel];
        out_data    = w_active ? req_data[int'(r_sel)*W +: W] : '0;
        out_last    = w_active && req_last[r_sel];
        req_ready   = '0;
        if (w_active) begin
            req_ready[r_sel] = out_ready;
        end
        w_xfer      = out_valid && out_ready;
        w_ptr_after = (r_sel == SW'(N-1)) ? '0 : r_sel + 1'b1;

        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick;
                    w_sel_nxt   = w_pick_idx;
                end
            end
            BUSY: begin
                if ((w_xfer && out_last) || w_wd_hit) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_after;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

`ifdef MUX_RR_ARBITER_WATCHDOG_EN
    localparam int CW = idx_w(TIMEOUT + 1);

    logic [CW-1:0] r_wd_cnt;
    logic          r_err;

    // Counts consecutive non-transfer cycles of the current grant.
    assign w_wd_hit = (r_state == BUSY) && !w_xfer && (r_wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != BUSY || w_xfer || w_wd_hit) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_wd_hit = 1'b0;
    assign err      = 1'b0;
`endif

    assign grant = r_grant;
    assign sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and randomized checks of mux_rr_arbiter against a packet-level model
module tb_mux_rr_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int SW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic [SW-1:0]   sel;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner of the shared port (-1 = nobody), rotation start, stall cycles, error flag.
    int m_owner;
    int m_ptr;
    int m_stall;
    bit m_err;
    logic [W-1:0] xfer_log[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .N       (N),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick_m();
        for (int i = 0; i < N; i++) begin
            if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // Check the current cycle against the model, then advance the model across one rising edge.
    task automatic step();
        bit act;
        int o;
        int k;
        #1;
        act = (m_owner >= 0) && !rst;
        o   = (m_owner >= 0) ? m_owner : 0;
        chk("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        if (m_owner >= 0) chk("sel", sel, m_owner);
        chk("out_valid", out_valid, act ? req_valid[o] : 1'b0);
        chk("out_data", out_data, act ? req_data[o*W +: W] : 8'h00);
        chk("out_last", out_last, act ? req_last[o] : 1'b0);
        chk("req_ready", req_ready, (act && out_ready) ? (32'd1 << o) : 32'd0);
        chk("err", err, m_err);
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_stall = 0;
            m_err   = 1'b0;
        end else if (m_owner < 0) begin
            k = pick_m();
            if (k >= 0) begin
                m_owner = k;
                m_stall = 0;
            end
        end else if (req_valid[m_owner] && out_ready) begin
            xfer_log.push_back(req_data[m_owner*W +: W]);
            m_stall = 0;
            if (req_last[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
`ifdef MUX_RR_ARBITER_WATCHDOG_EN
            m_stall++;
            if (m_stall == TO) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_err   = 1'b1;
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int b;
        logic [W-1:0] exp3[4];
        exp3[0] = 8'h10; exp3[1] = 8'h20; exp3[2] = 8'h10; exp3[3] = 8'h20;

        // Bring registers out of X before any model comparison.
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        m_owner = -1; m_ptr = 0; m_stall = 0; m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles, then idle.
        step();
        step();
        chk("rst_sel", sel, 0);
        rst = 1'b0;
        step();
        step();

        // Single 3-beat packet from requester 0.
        xfer_log.delete();
        b = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12 && b < 3; c++) begin
            req_valid = 3'b001;
            req_data[0 +: W] = 8'hA1 + 8'(b);
            req_last[0] = (b == 2);
            step();
            b = xfer_log.size();
        end
        req_valid = '0; req_last = '0;
        chk("pkt_beats", xfer_log.size(), 3);
        for (int i = 0; i < 3 && i < xfer_log.size(); i++) chk("pkt_data", xfer_log[i], 8'hA1 + i);
        chk("pkt_release", grant, 0);
        step();

        // Two requesters contending with single-beat packets.
        do_reset();
        xfer_log.delete();
        req_valid = 3'b011; req_last = 3'b011; out_ready = 1'b1;
        req_data = '0; req_data[0 +: W] = 8'h10; req_data[W +: W] = 8'h20;
        for (int c = 0; c < 8; c++) step();
        chk("rot_count", xfer_log.size(), 4);
        for (int i = 0; i < 4 && i < xfer_log.size(); i++) chk("rot_data", xfer_log[i], exp3[i]);

        // Backpressure mid-packet on requester 1 while requester 0 waits.
        do_reset();
        req_valid = 3'b010; req_last = '0; out_ready = 1'b1;
        req_data[W +: W] = 8'h55;
        step();
        step();
        req_valid = 3'b011; out_ready = 1'b0; req_data[W +: W] = 8'h66; req_data[0 +: W] = 8'h99;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_data", out_data, 8'h66);
            chk("bp_ready", req_ready, 0);
            chk("bp_grant", grant, 3'b010);
        end
        out_ready = 1'b1; req_last = 3'b010;
        step();
        chk("bp_release", grant, 0);
        req_last = 3'b000;
        step();
        chk("bp_next", grant, 3'b001);

        // Reset on the second beat of a packet.
        do_reset();
        req_valid = 3'b001; req_last = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        chk("mr_grant", grant, 0);
        chk("mr_valid", out_valid, 0);
        rst = 1'b0;
        req_valid = 3'b011;
        step();
        chk("mr_restart", grant, 3'b001);

`ifdef MUX_RR_ARBITER_WATCHDOG_EN
        // Stalled grant force-released by the watchdog.
        do_reset();
        req_valid = 3'b011; req_last = '0; out_ready = 1'b0;
        step();
        chk("wd_grant", grant, 3'b001);
        for (int c = 0; c < TO; c++) step();
        chk("wd_release", grant, 0);
        chk("wd_err", err, 1);
        step();
        chk("wd_next", grant, 3'b010);
        for (int c = 0; c < 4; c++) step();
        chk("wd_sticky", err, 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = N'($urandom);
            req_data  = (N*W)'({$urandom, $urandom});
            for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
